mix_columns_unit: RTL and testbench
===================================

Name: mix_columns_unit

Overview:
- Registered AES MixColumns / InvMixColumns stage (FIPS-197 §5.1.3, §5.3.3) for the round datapath.
- Sits between ShiftRows and AddRoundKey in encryption, and between AddRoundKey and InvShiftRows in decryption.
- One instance serves both directions, selected per transfer by a mode input.
- Valid-qualified, one-cycle-latency pipeline stage.

Parameters:
- None.

Ports:
- clock       input   1    system clock, rising-edge active
- reset       input   1    asynchronous, active-low reset
- validInput  input   1    data_in and inverse are valid this cycle
- inverse     input   1    0 = MixColumns, 1 = InvMixColumns
- data_in     input   128  AES state
- validOutput output  1    data_out valid
- data_out    output  128  transformed state

Behaviour:
- Reset is asynchronous and active-low: reset=0 immediately forces data_out=128'h0 and validOutput=0, independent of clock.
- State byte order:
  - data_in[127:120] = s0,0, [119:112] = s1,0, [111:104] = s2,0, [103:96] = s3,0.
  - Column c occupies bits [127-32c -: 32], with row 0 in the MSB byte.
  - data_out uses the same order.
- Per column (a0..a3 → b0..b3), each output row is an XOR of GF(2^8) products.
- Forward (MixColumns) coefficients, per output row:
  - b0: 02·a0, 03·a1, 01·a2, 01·a3
  - b1: 01·a0, 02·a1, 03·a2, 01·a3
  - b2: 01·a0, 01·a1, 02·a2, 03·a3
  - b3: 03·a0, 01·a1, 01·a2, 02·a3
- Inverse (InvMixColumns) coefficients, per output row:
  - b0: 0e·a0, 0b·a1, 0d·a2, 09·a3
  - b1: 09·a0, 0e·a1, 0b·a2, 0d·a3
  - b2: 0d·a0, 09·a1, 0e·a2, 0b·a3
  - b3: 0b·a0, 0d·a1, 09·a2, 0e·a3
- GF arithmetic:
  - Field polynomial x^8+x^4+x^3+x+1.
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
  - Products are built from xtime chains, e.g. 09 = x8 ^ x1 and 0e = x8 ^ x4 ^ x2.
  - Purely combinational. No lookup tables, no multipliers.
- All four columns are processed in parallel. Both transforms are computed and a 128-bit mux on inverse selects one.
- Latency:
  - On a rising clock edge with validInput=1, data_out <= f(data_in, inverse) and validOutput <= 1.
  - On a rising clock edge with validInput=0, validOutput <= 0 and data_out holds its previous value.
- Throughput: one state per cycle. Back-to-back valid inputs are allowed, and inverse may change every cycle.
- Round-trip identity: the inverse transform applied to the forward result returns the original input exactly.
- Reset asserted mid-stream: the in-flight result is discarded. After release, the first valid output appears 1 cycle after the first sampled validInput=1.
- No backpressure, no stall input.

Optional Feature:
- Macro: MIXCOL_PIPE2_EN.
- When defined:
  - Adds a second register stage: the GF products/partial XORs are registered, then the final XOR and mux output is registered.
  - Latency becomes 2 cycles; validOutput is delayed by 2.
  - Both stages are cleared by reset. Throughput is unchanged at one per cycle.
- When undefined: single-stage, 1-cycle latency as above.

Test Plan:
- Reset: assert reset=0 mid-cycle with a valid in flight → data_out=0 and validOutput=0 asynchronously. Release, idle → outputs stay 0.
- Forward FIPS vector: inverse=0, data_in=d4bf5d30e0b452aeb84111f11e2798e5, validInput=1 → next cycle data_out=046681e5e0cb199a48f8d37a2806264c, validOutput=1.
- Inverse FIPS vector: inverse=1, data_in=046681e5e0cb199a48f8d37a2806264c → data_out=d4bf5d30e0b452aeb84111f11e2798e5.
- Fixed points and xtime reduction:
  - Forward on column db135345 → 8e4da1bc.
  - Forward on all-01 → all-01.
  - Forward on c6c6c6c6 per column → c6c6c6c6.
- Back-to-back traffic: alternate inverse=0/1 on consecutive cycles with random states → each output matches the reference model one cycle later (two cycles with MIXCOL_PIPE2_EN).
- Hold and round trip:
  - Drop validInput for 3 cycles → validOutput=0 and data_out unchanged.
  - Random state through forward, then fed back with inverse=1 → the original state.

Source files
------------

// File: rtl/mix_columns_unit.sv
// AES MixColumns / InvMixColumns round stage, valid-qualified, direction chosen per transfer.
// Define MIXCOL_PIPE2_EN to register the xtime products ahead of the final XOR/mux (2-cycle latency).
module mix_columns_unit (
    input  logic         clock,
    input  logic         reset,
    input  logic         validInput,
    input  logic         inverse,
    input  logic [127:0] data_in,
    output logic         validOutput,
    output logic [127:0] data_out
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [127:0] x2_c, x4_c, x8_c;

    always_comb begin
        x2_c = '0;
        x4_c = '0;
        x8_c = '0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] t2, t4;
            t2 = xtime(data_in[i*8 +: 8]);
            t4 = xtime(t2);
            x2_c[i*8 +: 8] = t2;
            x4_c[i*8 +: 8] = t4;
            x8_c[i*8 +: 8] = xtime(t4);
        end
    end

    logic [127:0] a_s, x2_s, x4_s, x8_s;
    logic         inv_s, vld_s;

`ifdef MIXCOL_PIPE2_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_s <= 1'b0;
            inv_s <= 1'b0;
            a_s   <= '0;
            x2_s  <= '0;
            x4_s  <= '0;
            x8_s  <= '0;
        end else begin
            vld_s <= validInput;
            if (validInput) begin
                inv_s <= inverse;
                a_s   <= data_in;
                x2_s  <= x2_c;
                x4_s  <= x4_c;
                x8_s  <= x8_c;
            end
        end
    end
`else
    assign vld_s = validInput;
    assign inv_s = inverse;
    assign a_s   = data_in;
    assign x2_s  = x2_c;
    assign x4_s  = x4_c;
    assign x8_s  = x8_c;
`endif

    logic [127:0] fwd_c, inv_c, result_c;

    // Row r of column c lives at bit 127-32c-8r; rows rotate through the circulant coefficients.
    always_comb begin
        fwd_c = '0;
        inv_c = '0;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] a0, a1, a2, a3;
            logic [7:0] m2_0, m2_1, m2_2, m2_3;
            logic [7:0] m4_0, m4_1, m4_2, m4_3;
            logic [7:0] m8_0, m8_1, m8_2, m8_3;
            a0   = a_s [127-32*c -: 8];
            a1   = a_s [119-32*c -: 8];
            a2   = a_s [111-32*c -: 8];
            a3   = a_s [103-32*c -: 8];
            m2_0 = x2_s[127-32*c -: 8];
            m2_1 = x2_s[119-32*c -: 8];
            m2_2 = x2_s[111-32*c -: 8];
            m2_3 = x2_s[103-32*c -: 8];
            m4_0 = x4_s[127-32*c -: 8];
            m4_1 = x4_s[119-32*c -: 8];
            m4_2 = x4_s[111-32*c -: 8];
            m4_3 = x4_s[103-32*c -: 8];
            m8_0 = x8_s[127-32*c -: 8];
            m8_1 = x8_s[119-32*c -: 8];
            m8_2 = x8_s[111-32*c -: 8];
            m8_3 = x8_s[103-32*c -: 8];

            fwd_c[127-32*c -: 8] = m2_0 ^ (m2_1 ^ a1) ^ a2 ^ a3;
            fwd_c[119-32*c -: 8] = a0 ^ m2_1 ^ (m2_2 ^ a2) ^ a3;
            fwd_c[111-32*c -: 8] = a0 ^ a1 ^ m2_2 ^ (m2_3 ^ a3);
            fwd_c[103-32*c -: 8] = (m2_0 ^ a0) ^ a1 ^ a2 ^ m2_3;

            // 0e = x8^x4^x2, 0b = x8^x2^x1, 0d = x8^x4^x1, 09 = x8^x1
            inv_c[127-32*c -: 8] = (m8_0 ^ m4_0 ^ m2_0) ^ (m8_1 ^ m2_1 ^ a1)
                                 ^ (m8_2 ^ m4_2 ^ a2)   ^ (m8_3 ^ a3);
            inv_c[119-32*c -: 8] = (m8_0 ^ a0)          ^ (m8_1 ^ m4_1 ^ m2_1)
                                 ^ (m8_2 ^ m2_2 ^ a2)   ^ (m8_3 ^ m4_3 ^ a3);
            inv_c[111-32*c -: 8] = (m8_0 ^ m4_0 ^ a0)   ^ (m8_1 ^ a1)
                                 ^ (m8_2 ^ m4_2 ^ m2_2) ^ (m8_3 ^ m2_3 ^ a3);
            inv_c[103-32*c -: 8] = (m8_0 ^ m2_0 ^ a0)   ^ (m8_1 ^ m4_1 ^ a1)
                                 ^ (m8_2 ^ a2)          ^ (m8_3 ^ m4_3 ^ m2_3);
        end
    end

    assign result_c = inv_s ? inv_c : fwd_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            validOutput <= 1'b0;
            data_out    <= '0;
        end else begin
            validOutput <= vld_s;
            if (vld_s) begin
                data_out <= result_c;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns_unit.sv
// Scoreboard bench for mix_columns_unit: expected states are queued at issue time, a monitor pops on validOutput.
module tb_mix_columns_unit;

`ifdef MIXCOL_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clock = 1'b0;
    logic         rst_n = 1'b1;
    logic         validInput = 1'b0;
    logic         inverse = 1'b0;
    logic [127:0] data_in = '0;
    logic         validOutput;
    logic [127:0] data_out;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];
    logic [127:0] last_exp = '0;

    mix_columns_unit dut (
        .clock      (clock),
        .reset      (rst_n),
        .validInput (validInput),
        .inverse    (inverse),
        .data_in    (data_in),
        .validOutput(validOutput),
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    // General shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0] base [4];
        logic [127:0] r = '0;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127-32*c-8*k -: 8], base[(k - row + 4) % 4]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %032h expected %032h", name, act, req);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp);
        @(posedge clock);
        #1;
        validInput = 1'b1;
        inverse    = inv;
        data_in    = d;
        exp_q.push_back(exp);
        last_exp = exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            validInput = 1'b0;
            data_in    = rand128();
            inverse    = $urandom_range(0, 1);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n && validOutput) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got %032h with nothing expected", data_out);
            end else begin
                check("scoreboard", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] x, y;
        #2 rst_n = 1'b0;
        #3;
        check("reset_data", data_out, '0);
        check("reset_valid", {127'h0, validOutput}, '0);
        #12 rst_n = 1'b1;

        send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
        send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        send({4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
        send({16{8'h01}}, 1'b0, {16{8'h01}});
        send({16{8'hc6}}, 1'b0, {16{8'hc6}});
        send({32'hdb135345, 32'h01010101, 32'hc6c6c6c6, 32'h00000000}, 1'b0,
             {32'h8e4da1bc, 32'h01010101, 32'hc6c6c6c6, 32'h00000000});

        for (int i = 0; i < 24; i++) begin
            x = rand128();
            send(x, i[0], model(x, i[0]));
        end

        idle(LAT + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_valid", {127'h0, validOutput}, '0);
            check("hold_data", data_out, last_exp);
        end

        for (int i = 0; i < 4; i++) begin
            x = rand128();
            send(x, 1'b0, model(x, 1'b0));
            idle(LAT);
            @(negedge clock);
            y = data_out;
            send(y, 1'b1, x);
            idle(LAT + 1);
        end

        x = rand128();
        send(x, 1'b0, model(x, 1'b0));
        send(rand128(), 1'b1, '0);
        @(posedge clock);
        #2;
        validInput = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midreset_data", data_out, '0);
        check("midreset_valid", {127'h0, validOutput}, '0);
        exp_q.delete();
        last_exp = '0;
        #4 rst_n = 1'b1;
        idle(LAT + 2);
        @(negedge clock);
        check("post_reset_data", data_out, '0);
        check("post_reset_valid", {127'h0, validOutput}, '0);

        x = rand128();
        send(x, 1'b1, model(x, 1'b1));
        idle(LAT + 2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
